// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for inv_mix_columns_seq: input block channel and result channel.
// The mode signal exists only when INV_MIX_FWD_EN is defined.
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
`ifdef INV_MIX_FWD_EN
  logic         mode;
`endif

  modport master (
    output in_valid,
    input  in_ready,
    output state_in,
    input  out_valid,
    output out_ready,
    input  state_out
`ifdef INV_MIX_FWD_EN
    ,
    output mode
`endif
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  state_in,
    output out_valid,
    input  out_ready,
    output state_out
`ifdef INV_MIX_FWD_EN
    ,
    input  mode
`endif
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one 32-bit column per clock, valid/ready in and out.
// Optional INV_MIX_FWD_EN adds a latched mode input selecting the forward MixColumns matrix.
module inv_mix_columns_seq (
  input logic                   clk,
  input logic                   rst,
  inv_mix_columns_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  logic [127:0] st;
  logic [1:0]   col;
  logic [31:0]  col_data;
  logic [31:0]  col_next;
`ifdef INV_MIX_FWD_EN
  logic         fwd;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Each output row rotates the {0e,0b,0d,09} coefficients right by one.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
            mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
            mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
            mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
  endfunction

`ifdef INV_MIX_FWD_EN
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
`endif

  always_comb begin
    col_data = '0;
    case (col)
      2'd0: col_data = st[127:96];
      2'd1: col_data = st[95:64];
      2'd2: col_data = st[63:32];
      2'd3: col_data = st[31:0];
    endcase
`ifdef INV_MIX_FWD_EN
    col_next = fwd ? fwd_col(col_data) : inv_col(col_data);
`else
    col_next = inv_col(col_data);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      col   <= '0;
`ifdef INV_MIX_FWD_EN
      fwd   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            st    <= bus.state_in;
            col   <= 2'd0;
            state <= BUSY;
`ifdef INV_MIX_FWD_EN
            fwd   <= bus.mode;
`endif
          end
        end
        BUSY: begin
          case (col)
            2'd0: st[127:96] <= col_next;
            2'd1: st[95:64]  <= col_next;
            2'd2: st[63:32]  <= col_next;
            2'd3: st[31:0]   <= col_next;
          endcase
          col <= col + 2'd1;
          if (col == 2'd3) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.state_out = st;

endmodule
